// File: rtl/mpu_int_div.sv
// Element-wise unsigned division of a ROWSxCOLS matrix by a scalar, using one
// restoring divider stepped one quotient bit per cycle over the elements in row-major order.
module mpu_int_div #(
  parameter int ROWS  = 5,
  parameter int COLS  = 5,
  parameter int WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_valid,
  output logic                        start_ready,
  input  logic [ROWS*COLS*WIDTH-1:0]  matrix,
  input  logic [WIDTH-1:0]            divisor,
  output logic [ROWS*COLS*WIDTH-1:0]  result,
  output logic                        result_valid,
  input  logic                        result_ready,
  output logic                        div_by_zero,
  output logic                        busy,
  output logic [1:0]                  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid, once raised, holds its payload stable until that edge.
  localparam int N  = ROWS * COLS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DIVIDE = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]         state;
  logic [N*WIDTH-1:0] mat_q;
  logic [WIDTH-1:0]   div_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [BW-1:0]      bit_cnt;
  logic [IW-1:0]      elem_idx;

  logic [WIDTH-1:0]   cur_elem;
  logic               dvd_bit;
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     diff;
  logic               ge;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic               last_elem;

  always_comb begin
    cur_elem = '0;
    for (int k = 0; k < N; k++) begin
      if (elem_idx == IW'(k)) cur_elem = mat_q[k*WIDTH +: WIDTH];
    end
    dvd_bit   = cur_elem[bit_cnt];
    trial     = {rem_q, dvd_bit};
    diff      = trial - {1'b0, div_q};
    ge        = (trial >= {1'b0, div_q});
    // The remainder is always below the divisor, so it fits in WIDTH bits.
    rem_next  = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_next  = {quo_q[WIDTH-2:0], ge};
    last_elem = (elem_idx == IW'(N-1));
  end

  assign start_ready = (state == IDLE);
  assign busy        = (state == DIVIDE);
  assign dbg_state   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mat_q        <= '0;
      div_q        <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      bit_cnt      <= '0;
      elem_idx     <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      div_by_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            mat_q <= matrix;
            div_q <= divisor;
            if (divisor == '0) begin
              result       <= '1;
              div_by_zero  <= 1'b1;
              result_valid <= 1'b1;
              state        <= DONE;
            end else begin
              div_by_zero <= 1'b0;
              elem_idx    <= '0;
              bit_cnt     <= BW'(WIDTH-1);
              rem_q       <= '0;
              quo_q       <= '0;
              state       <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          if (bit_cnt == '0) begin
            for (int k = 0; k < N; k++) begin
              if (elem_idx == IW'(k)) result[k*WIDTH +: WIDTH] <= quo_next;
            end
            rem_q   <= '0;
            bit_cnt <= BW'(WIDTH-1);
            if (last_elem) begin
              result_valid <= 1'b1;
              state        <= DONE;
            end else begin
              elem_idx <= elem_idx + 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        DONE: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
